// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and reset constants for the instruction/LSU memory port arbiter.
package mem_arb_pkg;
  typedef enum logic {MST_INSTR = 1'b0, MST_DATA = 1'b1} mst_id_e;
  typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} lock_state_e;
  localparam mst_id_e LAST_GRANT_RST = MST_DATA;
endpackage

// File: rtl/owner_fifo.sv
// owner_fifo: in-order queue of master IDs for granted transactions still awaiting a response.
module owner_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  mst_id_e id_i,
  input  logic    pop_i,
  output mst_id_e id_o,
  output logic    empty_o,
  output logic    full_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0] ids_q, ids_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    empty_o = cnt_q == '0;
    full_o  = cnt_q == CW'(DEPTH);
    id_o    = mst_id_e'(ids_q[rptr_q]);
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    ids_d   = ids_q;
    if (do_push) ids_d[wptr_q] = id_i;
    wptr_d = do_push ? (wptr_q == PW'(DEPTH - 1) ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d = do_pop ? (rptr_q == PW'(DEPTH - 1) ? '0 : rptr_q + 1'b1) : rptr_q;
    cnt_d  = (do_push && !do_pop) ? cnt_q + 1'b1 : (do_pop && !do_push) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ids_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      ids_q  <= ids_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between instruction fetch and LSU.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
  lock_state_e state_q, state_d;
  mst_id_e lock_owner_q, lock_owner_d, last_grant_q, last_grant_d, sel, head_id;
  logic full, empty, hs, is_data;
  always_comb begin
    sel = (state_q == ST_LOCKED) ? lock_owner_q :
          (instr_req_i && data_req_i) ? (last_grant_q == MST_DATA ? MST_INSTR : MST_DATA) :
          (data_req_i ? MST_DATA : MST_INSTR);
    is_data     = sel == MST_DATA;
    mem_req_o   = rst_n && (is_data ? data_req_i : instr_req_i) && !full;
    hs          = mem_req_o && mem_gnt_i;
    mem_addr_o  = is_data ? data_addr_i : instr_addr_i;
    mem_we_o    = is_data && data_we_i;
    mem_be_o    = is_data ? data_be_i : '1;
    mem_wdata_o = is_data ? data_wdata_i : '0;
    instr_gnt_o = hs && !is_data;
    data_gnt_o  = hs && is_data;
    instr_rvalid_o = mem_rvalid_i && !empty && head_id == MST_INSTR;
    data_rvalid_o  = mem_rvalid_i && !empty && head_id == MST_DATA;
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
  end
  // A request offered but not accepted pins the owner so its address stays on the bus.
  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    last_grant_d = last_grant_q;
    if (hs) begin
      state_d      = ST_UNLOCKED;
      last_grant_d = sel;
    end else if (mem_req_o) begin
      state_d      = ST_LOCKED;
      lock_owner_d = sel;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_UNLOCKED;
      lock_owner_q <= MST_INSTR;
      last_grant_q <= LAST_GRANT_RST;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      last_grant_q <= last_grant_d;
    end
  end
  owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_owner_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (hs),
    .id_i   (sel),
    .pop_i  (mem_rvalid_i),
    .id_o   (head_id),
    .empty_o(empty),
    .full_o (full)
  );
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter that shares one single-port memory between the core's instruction fetch interface and its data (LSU) interface using the req/gnt/rvalid handshake. It sits between `core` and the memory model/SRAM macro. It arbitrates round-robin, keeps a losing request's address stable until it is granted, and routes each in-order response back to the master that issued it.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width; `be` is `DATA_WIDTH/8` bits
- `MAX_OUTSTANDING`, 2, granted-but-unanswered transactions allowed (power of two, ≥1)

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `instr_req_i`, `instr_addr_i`  in  1/ADDR_WIDTH  fetch request (read only)
- `instr_gnt_o`, `instr_rvalid_o`, `instr_rdata_o`  out  1/1/DATA_WIDTH  fetch grant/response
- `data_req_i`, `data_addr_i`, `data_we_i`, `data_be_i`, `data_wdata_i`  in  LSU request
- `data_gnt_o`, `data_rvalid_o`, `data_rdata_o`  out  LSU grant/response
- `mem_req_o`, `mem_addr_o`, `mem_we_o`, `mem_be_o`, `mem_wdata_o`  out  memory request
- `mem_gnt_i`, `mem_rvalid_i`, `mem_rdata_i`  in  memory grant/response

## Operation
- Selection (combinational):
  - `lock` set → owner = `lock_owner`.
  - Else exactly one request → that master.
  - Both requesting → the master not equal to `last_grant`.
- `mem_req_o` = selected request AND NOT `full`. Mux addr/we/be/wdata from the owner. Instr side drives `we=0`, `be='1`, `wdata=0`.
- Owner grant = `mem_gnt_i & mem_req_o & selected`. The non-selected master's grant is always 0.
- Lock state machine:
  - UNLOCKED→LOCKED when `mem_req_o & !mem_gnt_i`; latch owner.
  - LOCKED→UNLOCKED on a handshake (`mem_req_o & mem_gnt_i`).
  - While `full`, the lock is held and `mem_req_o` is 0.
- `last_grant` updates to the granted master on every handshake.
- Owner FIFO (`MAX_OUTSTANDING` entries, 1-bit IDs): push the granted ID on handshake, pop on `mem_rvalid_i`. Push and pop in the same cycle leaves the count unchanged.
- Response routing: `rdata` goes to both masters. Only `rvalid` of the FIFO-head owner asserts.
- `mem_rvalid_i` with an empty FIFO: ignored, no pop, no master rvalid.
- `full` = count == MAX_OUTSTANDING. A pop in the same cycle does NOT lift `full`; this avoids a combinational gnt→rvalid path.

## Timing
- Request to memory: 0 cycles, combinational from `*_req_i`.
- Grant: same cycle as `mem_gnt_i`.
- Response: same cycle as `mem_rvalid_i`, combinational pass-through.
- Responses are in order; the memory must answer at least 1 cycle after its grant.
- Reset values:
  - `lock`=0, `last_grant`=DATA, so INSTR wins the first tie.
  - FIFO count=0.
  - All `*_gnt_o`, `*_rvalid_o`, `mem_req_o` = 0 while `rst_n`=0.
- Reset mid-operation: outstanding IDs are discarded. Responses arriving after reset hit the empty-FIFO rule.
- Back-to-back handshakes are allowed every cycle while not `full`. With MAX_OUTSTANDING=1, one transaction completes every 2 cycles.

## Structure
- New package `mem_arb_pkg`:
  - `typedef enum logic {MST_INSTR=1'b0, MST_DATA=1'b1} mst_id_e`
  - reset value of `last_grant`
- Sub-module `owner_fifo`: parameter DEPTH. Ports `push_i`, `id_i`, `pop_i`, `id_o`, `empty_o`, `full_o`, `clk`, `rst_n`. Pointer wrap is modulo DEPTH.
- Top-level keeps the lock FSM, round-robin register and muxes (~200 lines total).

## Test plan
- Instr only, addr 0x08, memory grants immediately and returns 0x00F00293 next cycle:
  - same-cycle `instr_gnt_o`
  - `instr_rvalid_o`=1 with that data, `data_rvalid_o`=0.
- Both request from reset (instr 0x0C, data 0x100 we=1), gnt always 1:
  - instr granted cycle 0, data cycle 1
  - then alternation while both hold requests.
- Memory holds `mem_gnt_i`=0 for 3 cycles with data selected; instr raises req during the stall:
  - `mem_addr_o` stays 0x100 for 3 cycles
  - data granted first, then instr.
- MAX_OUTSTANDING=2, two grants with no rvalid:
  - third request sees `mem_req_o`=0
  - one rvalid pops to the first owner; the next cycle grants again.
- Mixed in-order responses (instr, data, instr):
  - rvalids route to instr, data, instr respectively
  - simultaneous gnt+rvalid keeps count constant.
- Assert `rst_n`=0 with 2 outstanding, release, then pulse `mem_rvalid_i`:
  - no master rvalid
  - FIFO empty, first tie goes to INSTR.
